// File: rtl/gray_tracker.sv
// Gray-code position tracker: decodes strobed Gray samples, accumulates legal +/-1 steps
// into a signed position, and flags illegal jumps. Define GRAY_SYNC_EN to add 2-flop input synchronizers.
module gray_tracker #(
  parameter int W     = 4,
  parameter int PW    = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     gray_in,
  input  logic             gray_valid,
  input  logic             clear,
  output logic [W-1:0]     bin_out,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCKED   = 2'b01,
    FAULT    = 2'b10
  } state_t;

  localparam logic signed [PW-1:0] ONE = PW'(1);

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [W-1:0] samp_gray;
  logic         samp_vld;

`ifdef GRAY_SYNC_EN
  logic [W-1:0] gray_p0, gray_p1;
  logic         vld_p0, vld_p1;

  // stage p0/p1: two-flop synchronizer ahead of decode
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_p0 <= '0;
      gray_p1 <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      gray_p0 <= gray_in;
      gray_p1 <= gray_p0;
      vld_p0  <= gray_valid;
      vld_p1  <= vld_p0;
    end
  end

  assign samp_gray = gray_p1;
  assign samp_vld  = vld_p1;
`else
  assign samp_gray = gray_in;
  assign samp_vld  = gray_valid;
`endif

  state_t                  state_q, state_nx;
  logic [W-1:0]            bin_q, bin_nx;
  logic signed [PW-1:0]    pos_q, pos_nx;
  logic                    dir_q, dir_nx;
  logic                    step_q, step_nx;
  logic                    err_q, err_nx;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_nx;

  logic [W-1:0] bin_new;
  logic [W-1:0] diff;
  logic         is_up, is_down, is_same;

  // bin_q doubles as the stored last value used for classification
  assign bin_new = gray2bin(samp_gray);
  assign diff    = bin_new - bin_q;
  assign is_same = (diff == '0);
  assign is_up   = (diff == W'(1));
  assign is_down = (diff == {W{1'b1}});

  always_comb begin
    state_nx   = state_q;
    bin_nx     = bin_q;
    pos_nx     = pos_q;
    dir_nx     = dir_q;
    step_nx    = 1'b0;
    err_nx     = 1'b0;
    err_cnt_nx = err_cnt_q;
    if (clear) begin
      state_nx = UNLOCKED;
      pos_nx   = '0;
      dir_nx   = 1'b0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (samp_vld) begin
            bin_nx   = bin_new;
            state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (samp_vld) begin
            bin_nx = bin_new;
            if (is_up) begin
              step_nx = 1'b1;
              dir_nx  = 1'b1;
              pos_nx  = pos_q + ONE;
            end else if (is_down) begin
              step_nx = 1'b1;
              dir_nx  = 1'b0;
              pos_nx  = pos_q - ONE;
            end else if (!is_same) begin
              err_nx     = 1'b1;
              err_cnt_nx = sat_inc(err_cnt_q);
              state_nx   = FAULT;
            end
          end
        end
        FAULT: begin
          if (samp_vld) begin
            bin_nx = bin_new;
            if (is_same || is_up || is_down) begin
              state_nx = LOCKED;
            end else begin
              err_nx     = 1'b1;
              err_cnt_nx = sat_inc(err_cnt_q);
            end
          end
        end
        default: state_nx = UNLOCKED;
      endcase
    end
  end

  // stage out: registered tracker state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      bin_q     <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_nx;
      bin_q     <= bin_nx;
      pos_q     <= pos_nx;
      dir_q     <= dir_nx;
      step_q    <= step_nx;
      err_q     <= err_nx;
      err_cnt_q <= err_cnt_nx;
    end
  end

  assign bin_out = bin_q;
  assign pos     = pos_q;
  assign dir     = dir_q;
  assign step    = step_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker; response latency follows the GRAY_SYNC_EN build option.
module tb_gray_tracker;

`ifdef GRAY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  gray_in;
  logic        gray_valid;
  logic        clear;
  logic [3:0]  bin_out;
  logic [15:0] pos;
  logic        dir;
  logic        step;
  logic        err;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  gray_tracker #(.W(4), .PW(16), .ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .gray_valid (gray_valid),
    .clear      (clear),
    .bin_out    (bin_out),
    .pos        (pos),
    .dir        (dir),
    .step       (step),
    .err        (err),
    .err_cnt    (err_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g_of(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // one valid sample, then wait until its response is visible
  task automatic apply(input logic [3:0] g);
    gray_in    = g;
    gray_valid = 1'b1;
    tick();
    gray_valid = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int step_cnt;
  int err_seen;

  initial begin
    rst        = 1'b1;
    gray_in    = 4'h0;
    gray_valid = 1'b0;
    clear      = 1'b0;
    do_reset();

    chk("rst_state",   32'(state),   32'h0);
    chk("rst_pos",     32'(pos),     32'h0);
    chk("rst_bin",     32'(bin_out), 32'h0);
    chk("rst_dir",     32'(dir),     32'h0);
    chk("rst_step",    32'(step),    32'h0);
    chk("rst_err",     32'(err),     32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);

    // up sweep 0..15 then 0, back to back
    step_cnt = 0;
    for (int i = 0; i <= 16; i++) begin
      gray_in    = g_of(i % 16);
      gray_valid = 1'b1;
      tick();
      if (step) step_cnt++;
      if (i == LAT - 1) chk("up_lock_state", 32'(state), 32'h1);
    end
    gray_valid = 1'b0;
    repeat (LAT - 1) begin
      tick();
      if (step) step_cnt++;
    end
    chk("up_steps",   32'(step_cnt), 32'd16);
    chk("up_pos",     32'(pos),      32'd16);
    chk("up_dir",     32'(dir),      32'h1);
    chk("up_err_cnt", 32'(err_cnt),  32'h0);
    tick();
    chk("idle_step",  32'(step),     32'h0);
    chk("idle_pos",   32'(pos),      32'd16);

    // down sweep with wrap through 0 -> 15
    do_reset();
    apply(g_of(0));
    step_cnt = 0;
    for (int b = 15; b >= 1; b--) begin
      apply(g_of(b));
      if (step) step_cnt++;
    end
    chk("dn_pos",     32'(pos),      32'hFFF1);
    chk("dn_dir",     32'(dir),      32'h0);
    chk("dn_err_cnt", 32'(err_cnt),  32'h0);
    chk("dn_steps",   32'(step_cnt), 32'd15);
    chk("dn_state",   32'(state),    32'h1);

    // illegal jump 3 -> 5, then 6 recovers
    do_reset();
    apply(4'b0010);
    apply(4'b0111);
    chk("ill_err",     32'(err),     32'h1);
    chk("ill_err_cnt", 32'(err_cnt), 32'h1);
    chk("ill_state",   32'(state),   32'h2);
    chk("ill_pos",     32'(pos),     32'h0);
    chk("ill_bin",     32'(bin_out), 32'h5);
    apply(4'b0101);
    chk("rec_state",   32'(state),   32'h1);
    chk("rec_step",    32'(step),    32'h0);
    chk("rec_bin",     32'(bin_out), 32'h6);
    chk("rec_pos",     32'(pos),     32'h0);

    // alternating 0 / 8: every sample illegal, counter saturates
    step_cnt = 0;
    err_seen = 0;
    for (int i = 0; i < 300; i++) begin
      apply((i % 2 == 0) ? 4'b0000 : 4'b1100);
      if (step) step_cnt++;
      if (err) err_seen++;
    end
    chk("sat_state",   32'(state),    32'h2);
    chk("sat_err_cnt", 32'(err_cnt),  32'd255);
    chk("sat_steps",   32'(step_cnt), 32'd0);
    chk("sat_errs",    32'(err_seen), 32'd300);

    // build pos=7 with err_cnt=1, then clear alongside a valid sample
    do_reset();
    apply(g_of(0));
    apply(g_of(2));
    apply(g_of(1));
    chk("pre_state", 32'(state), 32'h1);
    for (int b = 2; b <= 8; b++) apply(g_of(b));
    chk("pre_pos",   32'(pos),     32'd7);
    clear      = 1'b1;
    gray_in    = g_of(9);
    gray_valid = 1'b1;
    tick();
    gray_valid = 1'b0;
    repeat (LAT - 1) tick();
    clear = 1'b0;
    chk("clr_pos",     32'(pos),     32'h0);
    chk("clr_state",   32'(state),   32'h0);
    chk("clr_err_cnt", 32'(err_cnt), 32'h1);
    chk("clr_bin",     32'(bin_out), 32'h8);
    chk("clr_dir",     32'(dir),     32'h0);
    apply(g_of(9));
    chk("relock_state", 32'(state),   32'h1);
    chk("relock_bin",   32'(bin_out), 32'h9);
    apply(g_of(10));
    chk("relock_pos",   32'(pos),     32'h1);
    chk("relock_dir",   32'(dir),     32'h1);

    // rst while a valid sample is presented
    rst        = 1'b1;
    gray_in    = g_of(11);
    gray_valid = 1'b1;
    tick();
    rst        = 1'b0;
    gray_valid = 1'b0;
    chk("mrst_state",   32'(state),   32'h0);
    chk("mrst_pos",     32'(pos),     32'h0);
    chk("mrst_bin",     32'(bin_out), 32'h0);
    chk("mrst_dir",     32'(dir),     32'h0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'h0);
    chk("mrst_step",    32'(step),    32'h0);
    repeat (LAT) tick();
    chk("mrst_lost",    32'(state),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
